cascade_counter_ctrl: RTL and testbench

CASCADE_COUNTER_CTRL -- requirements
Module: cascade_counter_ctrl

---
 rtl/cascade_counter_ctrl_pkg.sv | 15 +
 rtl/cascade_counter_ctrl_digit.sv | 59 +++++
 rtl/cascade_counter_ctrl.sv | 175 +++++++++++++++++
 tb/tb_cascade_counter_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cascade_counter_ctrl_pkg.sv
// Shared types and default sizing for the cascaded digit counter.
package cascade_counter_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    localparam int DEF_WIDTH       = 4;
    localparam int DEF_MOD         = 10;
    localparam int DEF_STAGES      = 2;
    localparam int DEF_AUTO_RELOAD = 0;

endpackage

// File: rtl/cascade_counter_ctrl_digit.sv
// One mod-MOD digit: clear > load > inc/dec, with ripple carry/borrow out.
module counter_digit
    import cascade_counter_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int MOD   = DEF_MOD
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] nxt_o,
    output logic             carry_o,
    output logic             borrow_o
);

    localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MOD);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MOD - 1);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] ld_sat;

    assign carry_o  = inc_i && (q_q == MAX_V);
    assign borrow_o = dec_i && (q_q == '0);
    assign ld_sat   = ({1'b0, load_val_i} >= MOD_W) ? MAX_V : load_val_i;
    assign q_o      = q_q;

    always_comb begin
        nxt_o = q_q;
        if (inc_i) begin
            nxt_o = carry_o ? '0 : q_q + 1'b1;
        end else if (dec_i) begin
            nxt_o = borrow_o ? MAX_V : q_q - 1'b1;
        end
    end

    always_comb begin
        q_d = nxt_o;
        if (clr_i) begin
            q_d = '0;
        end else if (load_i) begin
            q_d = ld_sat;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

endmodule

// File: rtl/cascade_counter_ctrl.sv
// Cascaded mod-MOD counter with IDLE/RUN/DONE control, load and wrap pulse.
module cascade_counter_ctrl
    import cascade_counter_ctrl_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int MOD         = DEF_MOD,
    parameter int STAGES      = DEF_STAGES,
    parameter int AUTO_RELOAD = DEF_AUTO_RELOAD
) (
    input  logic                    CK,
    input  logic                    RST,
    input  logic                    CLR,
    input  logic                    START,
    input  logic                    EN,
    input  logic                    DIR,
    input  logic                    LOAD,
    input  logic [STAGES*WIDTH-1:0] LOAD_VAL,
    input  logic [STAGES*WIDTH-1:0] LIMIT,
    output logic [STAGES*WIDTH-1:0] CNT,
    output logic                    BUSY,
    output logic                    DONE,
    output logic                    WRAP
);

    localparam int NB = STAGES * WIDTH;
    localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MOD);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MOD - 1);

    state_e          state_q;
    logic            dir_q;
    logic            busy_q;
    logic            done_q;
    logic            wrap_q;

    logic [NB-1:0]   lim_sat;
    logic [NB-1:0]   cnt_q;
    logic [NB-1:0]   nxt;
    logic [NB-1:0]   ld_val;
    logic [NB-1:0]   start_val;
    logic [NB-1:0]   tgt_start;
    logic [NB-1:0]   rel_val;
    logic [NB-1:0]   tgt_run;
    logic            ld;
    logic            step;
    logic [STAGES:0] inc_c;
    logic [STAGES:0] dec_c;

    assign inc_c[0] = step && !dir_q;
    assign dec_c[0] = step && dir_q;

    // Ripple chain: digit k's carry/borrow drives digit k+1 in the same cycle.
    for (genvar k = 0; k < STAGES; k++) begin : g_digit
        assign lim_sat[k*WIDTH +: WIDTH] =
            ({1'b0, LIMIT[k*WIDTH +: WIDTH]} >= MOD_W) ?
            MAX_V : LIMIT[k*WIDTH +: WIDTH];

        counter_digit #(
            .WIDTH (WIDTH),
            .MOD   (MOD)
        ) u_digit (
            .clk_i      (CK),
            .rst_i      (RST),
            .clr_i      (CLR),
            .load_i     (ld),
            .load_val_i (ld_val[k*WIDTH +: WIDTH]),
            .inc_i      (inc_c[k]),
            .dec_i      (dec_c[k]),
            .q_o        (cnt_q[k*WIDTH +: WIDTH]),
            .nxt_o      (nxt[k*WIDTH +: WIDTH]),
            .carry_o    (inc_c[k+1]),
            .borrow_o   (dec_c[k+1])
        );
    end

    assign start_val = DIR ? lim_sat : '0;
    assign tgt_start = DIR ? '0 : lim_sat;
    assign rel_val   = dir_q ? lim_sat : '0;
    assign tgt_run   = dir_q ? '0 : lim_sat;

    always_comb begin
        ld     = 1'b0;
        step   = 1'b0;
        ld_val = LOAD_VAL;
        if (CLR) begin
            ld = 1'b0;
        end else if (LOAD) begin
            ld = 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (START) begin
                        ld     = 1'b1;
                        ld_val = start_val;
                    end
                end
                S_RUN: begin
                    step = EN;
                end
                S_DONE: begin
                    if (AUTO_RELOAD != 0) begin
                        ld     = 1'b1;
                        ld_val = rel_val;
                    end
                end
                default: begin
                    ld = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            dir_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            if (CLR) begin
                state_q <= S_IDLE;
                dir_q   <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
            end else if (!LOAD) begin
                unique case (state_q)
                    S_IDLE: begin
                        if (START) begin
                            dir_q  <= DIR;
                            busy_q <= 1'b1;
                            if (start_val == tgt_start) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= S_RUN;
                            end
                        end
                    end
                    S_RUN: begin
                        if (EN) begin
                            wrap_q <= inc_c[STAGES] | dec_c[STAGES];
                            if (nxt == tgt_run) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                    S_DONE: begin
                        done_q <= 1'b0;
                        if (AUTO_RELOAD != 0) begin
                            if (rel_val == tgt_run) begin
                                done_q <= 1'b1;
                            end else begin
                                state_q <= S_RUN;
                            end
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign CNT  = cnt_q;
    assign BUSY = busy_q;
    assign DONE = done_q;
    assign WRAP = wrap_q;

endmodule

// File: tb/tb_cascade_counter_ctrl.sv
// Scoreboard bench: one-shot and auto-reload instances against an integer model.
module tb_cascade_counter_ctrl;

    localparam int W  = 4;
    localparam int M  = 10;
    localparam int S  = 2;
    localparam int NT = 100;
    localparam int IDLE = 0;
    localparam int RUN  = 1;
    localparam int DN   = 2;

    typedef struct packed {
        logic [7:0] c;
        logic       b;
        logic       d;
        logic       w;
    } obs_t;

    typedef struct packed {
        obs_t a;
        obs_t r;
    } exp_t;

    logic       CK = 1'b0;
    logic       RST = 1'b1;
    logic       CLR = 1'b0;
    logic       START = 1'b0;
    logic       EN = 1'b0;
    logic       DIR = 1'b0;
    logic       LOAD = 1'b0;
    logic [7:0] LOAD_VAL = '0;
    logic [7:0] LIMIT = '0;
    logic [7:0] cnt0, cnt1;
    logic       busy0, busy1, done0, done1, wrap0, wrap1;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];
    int   m_mode[2];
    int   m_n[2];
    bit   m_dir[2];

    always #5 CK = ~CK;

    cascade_counter_ctrl #(.WIDTH(W), .MOD(M), .STAGES(S), .AUTO_RELOAD(0)) u0 (
        .CK(CK), .RST(RST), .CLR(CLR), .START(START), .EN(EN), .DIR(DIR),
        .LOAD(LOAD), .LOAD_VAL(LOAD_VAL), .LIMIT(LIMIT),
        .CNT(cnt0), .BUSY(busy0), .DONE(done0), .WRAP(wrap0));

    cascade_counter_ctrl #(.WIDTH(W), .MOD(M), .STAGES(S), .AUTO_RELOAD(1)) u1 (
        .CK(CK), .RST(RST), .CLR(CLR), .START(START), .EN(EN), .DIR(DIR),
        .LOAD(LOAD), .LOAD_VAL(LOAD_VAL), .LIMIT(LIMIT),
        .CNT(cnt1), .BUSY(busy1), .DONE(done1), .WRAP(wrap1));

    function automatic int to_int(logic [7:0] v);
        int r = 0;
        int mul = 1;
        for (int k = 0; k < S; k++) begin
            int d;
            d = int'(v[k*W +: W]);
            if (d >= M) d = M - 1;
            r += d * mul;
            mul *= M;
        end
        return r;
    endfunction

    function automatic logic [7:0] to_bcd(int n);
        logic [7:0] r = '0;
        int x = n;
        for (int k = 0; k < S; k++) begin
            r[k*W +: W] = 4'(x % M);
            x = x / M;
        end
        return r;
    endfunction

    function automatic obs_t model(int i, bit ar);
        obs_t o;
        bit   wr = 1'b0;
        int   lim = to_int(LIMIT);
        int   tgt;
        if (CLR) begin
            m_n[i] = 0;
            m_mode[i] = IDLE;
            m_dir[i] = 1'b0;
        end else if (LOAD) begin
            m_n[i] = to_int(LOAD_VAL);
        end else if (m_mode[i] == IDLE) begin
            if (START) begin
                m_dir[i] = DIR;
                m_n[i] = DIR ? lim : 0;
                tgt = DIR ? 0 : lim;
                m_mode[i] = (m_n[i] == tgt) ? DN : RUN;
            end
        end else if (m_mode[i] == RUN) begin
            if (EN) begin
                if (!m_dir[i]) begin
                    wr = (m_n[i] == NT - 1);
                    m_n[i] = (m_n[i] + 1) % NT;
                end else begin
                    wr = (m_n[i] == 0);
                    m_n[i] = (m_n[i] + NT - 1) % NT;
                end
                tgt = m_dir[i] ? 0 : lim;
                if (m_n[i] == tgt) m_mode[i] = DN;
            end
        end else begin
            if (ar) begin
                m_n[i] = m_dir[i] ? lim : 0;
                tgt = m_dir[i] ? 0 : lim;
                m_mode[i] = (m_n[i] == tgt) ? DN : RUN;
            end else begin
                m_mode[i] = IDLE;
            end
        end
        o.c = to_bcd(m_n[i]);
        o.b = (m_mode[i] != IDLE);
        o.d = (m_mode[i] == DN);
        o.w = wr;
        return o;
    endfunction

    task automatic tick();
        exp_t e;
        e.a = model(0, 1'b0);
        e.r = model(1, 1'b1);
        sb.push_back(e);
        @(posedge CK);
        @(negedge CK);
    endtask

    task automatic chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic cmp_obs(string name, obs_t act, obs_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: cnt/busy/done/wrap got %h/%b/%b/%b want %h/%b/%b/%b",
                     name, $time, act.c, act.b, act.d, act.w,
                     exp.c, exp.b, exp.d, exp.w);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge CK);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                cmp_obs("sb_u0", {cnt0, busy0, done0, wrap0}, e.a);
                cmp_obs("sb_u1", {cnt1, busy1, done1, wrap1}, e.r);
            end
        end
    end

    task automatic pulse_clr();
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
    endtask

    initial begin
        int ones;
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = IDLE;
            m_n[i] = 0;
            m_dir[i] = 1'b0;
        end
        #2;
        chk("rst_cnt0", int'(cnt0), 0);
        chk("rst_flags0", int'({busy0, done0, wrap0}), 0);
        chk("rst_cnt1", int'(cnt1), 0);
        #10;
        RST = 1'b0;
        @(negedge CK);

        // up one-shot to 25
        LIMIT = 8'h25; DIR = 1'b0; EN = 1'b1; START = 1'b1;
        tick();
        START = 1'b0;
        chk("up_start_cnt", int'(cnt0), 0);
        chk("up_start_busy", int'(busy0), 1);
        repeat (24) tick();
        chk("up_24", int'(cnt0), 8'h24);
        chk("up_24_done", int'(done0), 0);
        tick();
        chk("up_25", int'(cnt0), 8'h25);
        chk("up_25_done", int'(done0), 1);
        tick();
        chk("up_after_done", int'({busy0, done0}), 0);
        chk("up_hold", int'(cnt0), 8'h25);

        // down auto-reload from 12
        pulse_clr();
        DIR = 1'b1; LIMIT = 8'h12; START = 1'b1;
        tick();
        START = 1'b0;
        chk("dn_start", int'(cnt1), 8'h12);
        repeat (11) tick();
        chk("dn_01", int'(cnt1), 8'h01);
        tick();
        chk("dn_00", int'(cnt1), 8'h00);
        chk("dn_done", int'(done1), 1);
        tick();
        chk("dn_reload", int'(cnt1), 8'h12);
        chk("dn_busy", int'({busy1, done1}), 2);

        // wrap through 99 -> 00
        pulse_clr();
        DIR = 1'b0; LIMIT = 8'h05; EN = 1'b0; START = 1'b1;
        tick();
        START = 1'b0;
        LOAD = 1'b1; LOAD_VAL = 8'h98;
        tick();
        LOAD = 1'b0;
        chk("wr_load", int'(cnt0), 8'h98);
        EN = 1'b1;
        tick();
        chk("wr_99", int'({cnt0, wrap0}), {8'h99, 1'b0});
        tick();
        chk("wr_00", int'({cnt0, wrap0}), {8'h00, 1'b1});
        tick();
        chk("wr_01", int'({cnt0, wrap0}), {8'h01, 1'b0});
        repeat (4) tick();
        chk("wr_05_done", int'({cnt0, done0}), {8'h05, 1'b1});

        // priority CLR > LOAD > count
        pulse_clr();
        LIMIT = 8'h99; EN = 1'b0; START = 1'b1;
        tick();
        START = 1'b0;
        LOAD = 1'b1; LOAD_VAL = 8'h40;
        tick();
        chk("pr_40", int'(cnt0), 8'h40);
        CLR = 1'b1; EN = 1'b1;
        tick();
        CLR = 1'b0; LOAD = 1'b0;
        chk("pr_clr", int'({cnt0, busy0}), 0);
        EN = 1'b0; START = 1'b1;
        tick();
        START = 1'b0;
        LOAD = 1'b1; LOAD_VAL = 8'hF3; EN = 1'b1;
        tick();
        LOAD = 1'b0;
        chk("pr_sat", int'({cnt0, busy0}), {8'h93, 1'b1});

        // async reset between edges
        pulse_clr();
        EN = 1'b0; START = 1'b1;
        tick();
        START = 1'b0;
        LOAD = 1'b1; LOAD_VAL = 8'h17;
        tick();
        LOAD = 1'b0;
        chk("ar_17", int'(cnt0), 8'h17);
        #2;
        RST = 1'b1;
        #1;
        chk("ar_cnt", int'({cnt0, cnt1}), 0);
        chk("ar_flags", int'({busy0, done0, busy1, done1}), 0);
        RST = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = IDLE;
            m_n[i] = 0;
            m_dir[i] = 1'b0;
        end
        @(negedge CK);
        EN = 1'b1;
        tick();
        chk("ar_no_done", int'({busy0, done0}), 0);

        // LIMIT=00 up: straight to DONE
        LIMIT = 8'h00; START = 1'b1;
        tick();
        START = 1'b0;
        chk("z_done", int'({cnt0, done0}), {8'h00, 1'b1});
        tick();
        pulse_clr();

        // EN toggling holds count on EN=0 cycles
        LIMIT = 8'h99; START = 1'b1;
        tick();
        START = 1'b0;
        ones = 0;
        for (int i = 0; i < 10; i++) begin
            EN = (i % 2 == 0);
            if (EN) ones++;
            tick();
            chk("en_tog", int'(cnt0), int'(to_bcd(ones)));
        end
        pulse_clr();

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            CLR   = ($urandom_range(0, 59) == 0);
            LOAD  = ($urandom_range(0, 19) == 0);
            START = ($urandom_range(0, 3) == 0);
            EN    = ($urandom_range(0, 3) != 0);
            DIR   = $urandom_range(0, 1) == 1;
            LOAD_VAL = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 29) == 0) begin
                if ($urandom_range(0, 3) == 0)
                    LIMIT = 8'($urandom_range(0, 255));
                else
                    LIMIT = to_bcd($urandom_range(0, 30));
            end
            tick();
        end
        CLR = 1'b0; LOAD = 1'b0; START = 1'b0; EN = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
